// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and the writeback/monitor consumer.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface alu_result_fifo_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_overflow;
    logic [4:0]        in_control;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_overflow;
    logic              out_zero;
    logic              out_neg;
    logic [4:0]        out_control;

    modport master (
        output in_valid, in_result, in_overflow, in_control, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_zero, out_neg, out_control
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_control, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_zero, out_neg, out_control
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results with per-entry zero/neg/overflow flags and a sticky overflow.
// Optional push/overflow statistics counters are enabled by defining ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_fifo_if.slave bus,
    input  logic             clr_sticky_i,
    output logic [ADDR_W:0]  count_o,
    output logic             sticky_ovf_o
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    output logic [15:0]      push_cnt_o,
    output logic [15:0]      ovf_cnt_o
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_result_q [DEPTH];
    logic              mem_ovf_q    [DEPTH];
    logic              mem_zero_q   [DEPTH];
    logic              mem_neg_q    [DEPTH];
    logic [4:0]        mem_ctrl_q   [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              sticky_q, sticky_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // Acceptance looks only at the registered count, so a full FIFO never admits
    // a push even when the consumer drains an entry in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_result   = mem_result_q[rd_ptr_q];
    assign bus.out_overflow = mem_ovf_q[rd_ptr_q];
    assign bus.out_zero     = mem_zero_q[rd_ptr_q];
    assign bus.out_neg      = mem_neg_q[rd_ptr_q];
    assign bus.out_control  = mem_ctrl_q[rd_ptr_q];

    assign count_o      = count_q;
    assign sticky_ovf_o = sticky_q;

    // Entry storage carries no reset; head data are ignored while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result_q[wr_ptr_q] <= bus.in_result;
            mem_ovf_q[wr_ptr_q]    <= bus.in_overflow;
            mem_zero_q[wr_ptr_q]   <= (bus.in_result == '0);
            mem_neg_q[wr_ptr_q]    <= bus.in_result[DATA_W-1];
            mem_ctrl_q[wr_ptr_q]   <= bus.in_control;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A set in the same cycle as a clear must win.
        if (clr_sticky_i) begin
            sticky_d = 1'b0;
        end
        if (push && bus.in_overflow) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] push_cnt_q, push_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        ovf_push;

    assign ovf_push = push && bus.in_overflow;

    // Clear with a coincident increment lands at 1; otherwise saturate at all-ones.
    always_comb begin
        push_cnt_d = push_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (clr_sticky_i) begin
            push_cnt_d = push ? 16'd1 : 16'd0;
            ovf_cnt_d  = ovf_push ? 16'd1 : 16'd0;
        end else begin
            if (push && (push_cnt_q != 16'hFFFF)) begin
                push_cnt_d = push_cnt_q + 16'd1;
            end
            if (ovf_push && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign push_cnt_o = push_cnt_q;
    assign ovf_cnt_o  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected entries, a monitor checks each pop.
module tb_alu_result_fifo;

    typedef struct packed {
        logic [31:0] r;
        logic        o;
        logic        z;
        logic        n;
        logic [4:0]  c;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr_sticky;
    logic [2:0] count;
    logic sticky_ovf;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] push_cnt;
    logic [15:0] ovf_cnt;
`endif

    int n_vec;
    int n_err;
    exp_t sb[$];

    alu_result_fifo_if #(.DATA_W(32)) bus ();

    alu_result_fifo #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_sticky_i (clr_sticky),
        .count_o      (count),
        .sticky_ovf_o (sticky_ovf)
`ifdef ALU_RESULT_FIFO_STATS_EN
        ,
        .push_cnt_o   (push_cnt),
        .ovf_cnt_o    (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Drive one push attempt; acc is the hand-derived acceptance expectation.
    task automatic push_one(input logic [31:0] d, input logic ovf, input logic [4:0] ctl,
                            input logic ez, input logic en, input logic acc,
                            input logic ordy, input logic clr);
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.in_result   = d;
        bus.in_overflow = ovf;
        bus.in_control  = ctl;
        bus.out_ready   = ordy;
        clr_sticky      = clr;
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(acc));
        if (acc) begin
            e = '{r: d, o: ovf, z: ez, n: en, c: ctl};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr_sticky   = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d entries outstanding, want 0", sb.size());
        end
        @(negedge clk);
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t want;
        exp_t got;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_vec++;
            got = '{r: bus.out_result, o: bus.out_overflow, z: bus.out_zero,
                    n: bus.out_neg, c: bus.out_control};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got result %h ctrl %h, want no entry", got.r, got.c);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL pop_entry: got r=%h o=%b z=%b n=%b c=%h, want r=%h o=%b z=%b n=%b c=%h",
                             got.r, got.o, got.z, got.n, got.c,
                             want.r, want.o, want.z, want.n, want.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n           = 1'b0;
        clr_sticky      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_result   = '0;
        bus.in_overflow = 1'b0;
        bus.in_control  = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset / idle
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
`ifdef ALU_RESULT_FIFO_STATS_EN
        chk("rst_push_cnt", 32'(push_cnt), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Zero result, next-cycle visibility
        push_one(32'h0000_0000, 1'b0, 5'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("zero_out_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_out_zero", 32'(bus.out_zero), 32'd1);
        chk("zero_out_neg", 32'(bus.out_neg), 32'd0);
        chk("zero_out_control", 32'(bus.out_control), 32'h04);
        chk("zero_count", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Fill to full; a 5th push with a same-cycle pop is refused
        push_one(32'h8000_0001, 1'b0, 5'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_one(32'h8000_0002, 1'b0, 5'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_one(32'h8000_0003, 1'b0, 5'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_one(32'h8000_0004, 1'b0, 5'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        @(posedge clk);
        #1;
        push_one(32'h8000_0005, 1'b0, 5'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_pop_count", 32'(count), 32'd3);
        @(posedge clk);
        #1;
        drain();

        // Streaming: one in, one out per cycle for 20 cycles
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            bus.in_valid    = 1'b1;
            bus.in_result   = 32'(i);
            bus.in_overflow = 1'b0;
            bus.in_control  = 5'(i);
            @(negedge clk);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            chk("stream_count", 32'(count), (i == 0) ? 32'd0 : 32'd1);
            e = '{r: 32'(i), o: 1'b0, z: (i == 0), n: 1'b0, c: 5'(i)};
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        drain();

        // Sticky overflow: set beats a coincident clear
        @(negedge clk);
        chk("sticky_before", 32'(sticky_ovf), 32'd0);
        @(posedge clk);
        #1;
        push_one(32'h7FFF_FFFF, 1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
`ifdef ALU_RESULT_FIFO_STATS_EN
        chk("stats_push_clr", 32'(push_cnt), 32'd1);
        chk("stats_ovf_clr", 32'(ovf_cnt), 32'd1);
`endif
        @(posedge clk);
        #1;
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 32'(sticky_ovf), 32'd0);
`ifdef ALU_RESULT_FIFO_STATS_EN
        chk("stats_push_zero", 32'(push_cnt), 32'd0);
        chk("stats_ovf_zero", 32'(ovf_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset with three entries held
        push_one(32'h1111_1111, 1'b0, 5'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_one(32'h2222_2222, 1'b0, 5'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_one(32'h3333_3333, 1'b1, 5'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_count", 32'(count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_sticky", 32'(sticky_ovf), 32'd0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_one(32'hDEAD_BEEF, 1'b0, 5'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_reset_count", 32'(count), 32'd1);
        chk("post_reset_head", bus.out_result, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
